vid_framebuf_banked: RTL and testbench
======================================

Name: vid_framebuf_banked

Overview:
- Parametrised next-generation video framebuffer: N_BANKS banks, each a pair of SB_SPRAM256KA (16k x 32 bits per bank).
- One fixed-latency video read port with absolute priority, plus N_AUX aux R/W ports with valid/ready handshakes.
- Aux ports are round-robin arbitrated. An aux access proceeds in parallel with video when it targets a different bank.
- Sits between the video scan-out engine and the CPU/DMA bus bridges.

Parameters:
- N_BANKS, 2, number of 16k x 32 banks (1, 2 or 4); AW = 14 + log2(N_BANKS).
- N_AUX, 2, number of aux ports (1..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- v_addr_0  in  AW  video word address; bank = top log2(N_BANKS) bits
- v_re_0  in  1  video read request; never stalled
- v_data_1  out  32  video read data; holds the last read value when no read
- v_valid_1  out  1  v_data_1 carries data read on the previous cycle
- a_addr_0  in  N_AUX*AW  per-port word address, port i at slice i
- a_wdata_0  in  N_AUX*32  per-port write data
- a_wmsk_0  in  N_AUX*4  per-port byte write mask, 1 = write byte
- a_we_0  in  N_AUX  per-port write (1) / read (0)
- a_valid_0  in  N_AUX  per-port request valid
- a_ready_0  out  N_AUX  per-port grant; transfer occurs when valid & ready
- a_rdata_1  out  32  aux read data, shared by all ports
- a_rvalid_1  out  N_AUX  one-hot; port i's read data is on a_rdata_1 this cycle

Behaviour:
- Reset (rst_n low at a clock edge):
  - Next cycle: v_valid_1 = 0, a_rvalid_1 = 0, v_data_1 hold register = 0, round-robin pointer = 0.
  - a_ready_0 is held at 0 combinationally while rst_n is low.
  - SPRAM contents are not cleared.
  - A reset arriving while a read is in flight suppresses that read's valid; its data is discarded.
- Video access:
  - v_re_0 = 1 drives v_addr_0 into the addressed bank; WREN = 0 on that bank.
  - v_valid_1 = 1 exactly one cycle later, with v_data_1 = RAM data.
  - On cycles following v_re_0 = 0, v_data_1 holds the last read word, via a register captured when a read completes.
- Bank conflict: aux port i is eligible when a_valid_0[i] and (~v_re_0 or bank(a_addr i) != bank(v_addr_0)). With N_BANKS = 1, no aux access is ever granted while v_re_0 = 1.
- Arbitration:
  - At most one aux grant per cycle.
  - Winner = first eligible port scanning upward from the round-robin pointer, wrapping modulo N_AUX.
  - a_ready_0 is combinational and one-hot, or all zero.
  - On a grant, the pointer becomes (winner + 1) mod N_AUX; otherwise it is unchanged.
  - Ineligible requesters see ready = 0, must hold address/data stable and keep valid asserted, and lose no priority.
- Aux write: occurs at the grant edge in the target bank.
  - MASKWREN nibbles = {m3, m3, m2, m2, m1, m1, m0, m0} (active-high nibble enables).
  - No a_rvalid_1 is raised for writes.
- Aux read: a_rvalid_1[winner] = 1 one cycle after the grant, with a_rdata_1 from the target bank.
  - The bank select and port id are registered at the grant.
  - a_rdata_1 is undefined when a_rvalid_1 = 0.
- Read data muxes:
  - Video and aux each use their own registered bank index. Video and aux completing in the same cycle from different banks must both be correct.
  - No address conflict between video and aux can exist, because the two never share a bank in the same cycle.
- Unused banks each cycle: WREN = 0, CHIPSELECT = 1, STANDBY/SLEEP = 0, POWEROFF = 1.

Test Plan:
- N_BANKS = 2, N_AUX = 2: port 0 writes 0xDEADBEEF with mask 0xF at 0x0010, then reads 0x0010. Expect ready high with v_re_0 = 0, then a_rvalid_1 = 01 with 0xDEADBEEF one cycle after the read grant.
- Byte mask: write 0x11223344 at mask 0xF, then 0xAABBCCDD at mask 0x5. A read returns 0x11BB33DD.
- Parallel banks: v_re_0 to 0x0005 (bank 0) and port 1 reading 0x4005 (bank 1) in the same cycle. Expect a_ready_0 = 10 and both valids next cycle with the correct distinct data. Then port 1 targets bank 0 during a video read: ready = 0 until v_re_0 drops.
- Round-robin: both ports hold valid continuously with v_re_0 = 0. Grants alternate 01, 10, 01, 10, starting from 01 after reset.
- Video hold: a video read returns X; idle v_re_0 for 5 cycles while aux writes elsewhere. v_data_1 stays X and v_valid_1 = 0.
- Reset mid-read: assert rst_n = 0 on the cycle after a read grant. The next cycle shows a_rvalid_1 = 0, v_valid_1 = 0 and a_ready_0 = 0. After release, the first grant goes to port 0.

Source files
------------

// File: rtl/vid_framebuf_banked.sv
// Banked video framebuffer: one never-stalled video read port plus N_AUX round-robin aux R/W ports.
// Each bank behaves as a paired SPRAM (16k x 32, nibble write enables, synchronous read).
module vid_framebuf_banked #(
  parameter int N_BANKS = 2,
  parameter int N_AUX   = 2,
  localparam int BW     = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  localparam int AW     = 14 + $clog2(N_BANKS),
  localparam int PW     = (N_AUX > 1) ? $clog2(N_AUX) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       v_addr_0,
  input  logic                v_re_0,
  output logic [31:0]         v_data_1,
  output logic                v_valid_1,
  input  logic [N_AUX*AW-1:0] a_addr_0,
  input  logic [N_AUX*32-1:0] a_wdata_0,
  input  logic [N_AUX*4-1:0]  a_wmsk_0,
  input  logic [N_AUX-1:0]    a_we_0,
  input  logic [N_AUX-1:0]    a_valid_0,
  output logic [N_AUX-1:0]    a_ready_0,
  output logic [31:0]         a_rdata_1,
  output logic [N_AUX-1:0]    a_rvalid_1
);

  function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] addr);
    if (N_BANKS == 1) return '0;
    else              return addr[AW-1 -: BW];
  endfunction

  logic [N_AUX-1:0] elig;
  logic [N_AUX-1:0] grant_oh;
  logic [PW-1:0]    win;
  logic             granted;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [AW-1:0]    w_addr;
  logic [31:0]      w_wdata;
  logic [3:0]       w_wmsk;
  logic             w_we;
  logic [BW-1:0]    v_bank, w_bank;

  logic [BW-1:0]    v_bank_q, a_bank_q;
  logic             v_valid_q;
  logic [N_AUX-1:0] a_rvalid_q, a_rvalid_d;
  logic [31:0]      v_hold_q;
  logic [31:0]      bank_rd [N_BANKS];

  assign v_bank = bank_of(v_addr_0);

  // A requester that shares the video bank this cycle simply waits; its place in the rotation is kept.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_AUX; i++) begin
      elig[i] = a_valid_0[i] &&
                (!v_re_0 || (bank_of(a_addr_0[i*AW +: AW]) != v_bank));
    end
  end

  always_comb begin
    win      = '0;
    granted  = 1'b0;
    grant_oh = '0;
    for (int k = 0; k < N_AUX; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % N_AUX;
      if (!granted && elig[idx]) begin
        granted = 1'b1;
        win     = PW'(idx);
      end
    end
    granted = granted && rst_n;
    if (granted) grant_oh[win] = 1'b1;
  end

  assign a_ready_0 = grant_oh;

  assign w_addr  = a_addr_0[win*AW +: AW];
  assign w_wdata = a_wdata_0[win*32 +: 32];
  assign w_wmsk  = a_wmsk_0[win*4 +: 4];
  assign w_we    = a_we_0[win];
  assign w_bank  = bank_of(w_addr);

  always_comb begin
    ptr_d      = ptr_q;
    a_rvalid_d = '0;
    if (granted) begin
      ptr_d = PW'((int'(win) + 1) % N_AUX);
      if (!w_we) a_rvalid_d[win] = 1'b1;
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [31:0] mem_q [16384];
    logic [31:0] rd_q;
    logic        v_sel, a_sel, wren;
    logic [13:0] addr;
    logic [7:0]  maskwren;

    assign v_sel    = v_re_0 && (v_bank == BW'(b));
    assign a_sel    = granted && (w_bank == BW'(b));
    assign addr     = v_sel ? v_addr_0[13:0] : w_addr[13:0];
    assign wren     = a_sel && w_we;
    assign maskwren = {{2{w_wmsk[3]}}, {2{w_wmsk[2]}}, {2{w_wmsk[1]}}, {2{w_wmsk[0]}}};

    always_ff @(posedge clk) begin
      if (wren) begin
        for (int n = 0; n < 8; n++) begin
          if (maskwren[n]) mem_q[addr][n*4 +: 4] <= w_wdata[n*4 +: 4];
        end
      end else if (v_sel || a_sel) begin
        rd_q <= mem_q[addr];
      end
    end

    assign bank_rd[b] = rd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      v_valid_q  <= 1'b0;
      a_rvalid_q <= '0;
      v_hold_q   <= '0;
      v_bank_q   <= '0;
      a_bank_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      v_valid_q  <= v_re_0;
      a_rvalid_q <= a_rvalid_d;
      if (v_re_0)  v_bank_q <= v_bank;
      if (granted) a_bank_q <= w_bank;
      if (v_valid_q) v_hold_q <= bank_rd[v_bank_q];
    end
  end

  assign v_valid_1  = v_valid_q;
  assign v_data_1   = v_valid_q ? bank_rd[v_bank_q] : v_hold_q;
  assign a_rvalid_1 = a_rvalid_q;
  assign a_rdata_1  = bank_rd[a_bank_q];

endmodule

// File: tb/tb_vid_framebuf_banked.sv
// Directed bench for vid_framebuf_banked with N_BANKS = 2, N_AUX = 2.
module tb_vid_framebuf_banked;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] v_addr_0;
  logic        v_re_0;
  logic [31:0] v_data_1;
  logic        v_valid_1;
  logic [29:0] a_addr_0;
  logic [63:0] a_wdata_0;
  logic [7:0]  a_wmsk_0;
  logic [1:0]  a_we_0;
  logic [1:0]  a_valid_0;
  logic [1:0]  a_ready_0;
  logic [31:0] a_rdata_1;
  logic [1:0]  a_rvalid_1;

  int n_assert = 0;
  int n_fail   = 0;

  vid_framebuf_banked #(.N_BANKS(2), .N_AUX(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .v_addr_0(v_addr_0), .v_re_0(v_re_0), .v_data_1(v_data_1), .v_valid_1(v_valid_1),
    .a_addr_0(a_addr_0), .a_wdata_0(a_wdata_0), .a_wmsk_0(a_wmsk_0), .a_we_0(a_we_0),
    .a_valid_0(a_valid_0), .a_ready_0(a_ready_0), .a_rdata_1(a_rdata_1), .a_rvalid_1(a_rvalid_1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic port(input int p, input logic [14:0] addr, input logic [31:0] d,
                      input logic [3:0] m, input logic we, input logic v);
    a_addr_0[p*15 +: 15] = addr;
    a_wdata_0[p*32 +: 32] = d;
    a_wmsk_0[p*4 +: 4]    = m;
    a_we_0[p]             = we;
    a_valid_0[p]          = v;
  endtask

  task automatic idle(input int p);
    port(p, 15'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  // Single granted write through port 0 while video is idle.
  task automatic wr0(input logic [14:0] addr, input logic [31:0] d, input logic [3:0] m);
    port(0, addr, d, m, 1'b1, 1'b1);
    cyc();
    idle(0);
  endtask

  initial begin
    rst_n = 1'b0; v_re_0 = 1'b0; v_addr_0 = '0;
    a_addr_0 = '0; a_wdata_0 = '0; a_wmsk_0 = '0; a_we_0 = '0; a_valid_0 = '0;

    // Reset: ready forced low even with requests pending
    port(0, 15'h0010, 32'h0, 4'h0, 1'b0, 1'b1);
    port(1, 15'h0020, 32'h0, 4'h0, 1'b0, 1'b1);
    #2;
    chk("rst_ready", 32'(a_ready_0), 32'h0);
    cyc(); cyc();
    chk("rst_vvalid", 32'(v_valid_1), 32'h0);
    chk("rst_rvalid", 32'(a_rvalid_1), 32'h0);
    chk("rst_vdata", v_data_1, 32'h0);
    idle(0); idle(1);
    rst_n = 1'b1;

    // Basic write then read on port 0
    port(0, 15'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    #1 chk("wr_ready", 32'(a_ready_0), 32'h1);
    cyc();
    chk("wr_no_rvalid", 32'(a_rvalid_1), 32'h0);
    port(0, 15'h0010, 32'h0, 4'h0, 1'b0, 1'b1);
    #1 chk("rd_ready", 32'(a_ready_0), 32'h1);
    cyc();
    idle(0);
    chk("rd_rvalid", 32'(a_rvalid_1), 32'h1);
    chk("rd_data", a_rdata_1, 32'hDEADBEEF);

    // Byte mask merge
    wr0(15'h0020, 32'h11223344, 4'hF);
    wr0(15'h0020, 32'hAABBCCDD, 4'h5);
    port(0, 15'h0020, 32'h0, 4'h0, 1'b0, 1'b1);
    cyc();
    idle(0);
    chk("mask_rvalid", 32'(a_rvalid_1), 32'h1);
    chk("mask_data", a_rdata_1, 32'h11BB33DD);

    // Parallel banks: video bank 0, port 1 bank 1
    wr0(15'h0005, 32'h00000505, 4'hF);
    wr0(15'h4005, 32'h40054005, 4'hF);
    wr0(15'h0006, 32'h66666666, 4'hF);
    v_re_0 = 1'b1; v_addr_0 = 15'h0005;
    port(1, 15'h4005, 32'h0, 4'h0, 1'b0, 1'b1);
    #1 chk("par_ready", 32'(a_ready_0), 32'h2);
    cyc();
    idle(1);
    chk("par_vvalid", 32'(v_valid_1), 32'h1);
    chk("par_vdata", v_data_1, 32'h00000505);
    chk("par_rvalid", 32'(a_rvalid_1), 32'h2);
    chk("par_adata", a_rdata_1, 32'h40054005);

    // Same-bank conflict: port 1 waits while video holds bank 0
    port(1, 15'h0006, 32'h0, 4'h0, 1'b0, 1'b1);
    #1 chk("conf_ready0", 32'(a_ready_0), 32'h0);
    cyc();
    chk("conf_ready1", 32'(a_ready_0), 32'h0);
    chk("conf_rvalid", 32'(a_rvalid_1), 32'h0);
    v_re_0 = 1'b0;
    #1 chk("conf_ready2", 32'(a_ready_0), 32'h2);
    cyc();
    idle(1);
    chk("conf_adata_v", 32'(a_rvalid_1), 32'h2);
    chk("conf_adata", a_rdata_1, 32'h66666666);
    chk("conf_vhold", v_data_1, 32'h00000505);
    chk("conf_vvalid", 32'(v_valid_1), 32'h0);

    // Round robin from reset
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    port(0, 15'h0010, 32'h0, 4'h0, 1'b0, 1'b1);
    port(1, 15'h0020, 32'h0, 4'h0, 1'b0, 1'b1);
    #1 chk("rr_g0", 32'(a_ready_0), 32'h1);
    cyc();
    chk("rr_g1", 32'(a_ready_0), 32'h2);
    chk("rr_d0", a_rdata_1, 32'hDEADBEEF);
    cyc();
    chk("rr_g2", 32'(a_ready_0), 32'h1);
    chk("rr_v1", 32'(a_rvalid_1), 32'h2);
    chk("rr_d1", a_rdata_1, 32'h11BB33DD);
    cyc();
    chk("rr_g3", 32'(a_ready_0), 32'h2);
    chk("rr_v2", 32'(a_rvalid_1), 32'h1);
    idle(0); idle(1);
    cyc();

    // Video hold across idle cycles while aux writes bank 0
    v_re_0 = 1'b1; v_addr_0 = 15'h4005;
    cyc();
    v_re_0 = 1'b0;
    chk("hold_first", v_data_1, 32'h40054005);
    for (int i = 0; i < 5; i++) begin
      port(0, 15'(15'h0030 + i), 32'h12340000 + i, 4'hF, 1'b1, 1'b1);
      cyc();
      chk($sformatf("hold_vvalid%0d", i), 32'(v_valid_1), 32'h0);
      chk($sformatf("hold_vdata%0d", i), v_data_1, 32'h40054005);
    end
    idle(0);

    // Reset mid-read
    v_re_0 = 1'b1; v_addr_0 = 15'h4005;
    port(0, 15'h0010, 32'h0, 4'h0, 1'b0, 1'b1);
    #1 chk("mid_ready", 32'(a_ready_0), 32'h1);
    cyc();
    rst_n = 1'b0;
    #1 chk("mid_ready_rst", 32'(a_ready_0), 32'h0);
    cyc();
    chk("mid_rvalid", 32'(a_rvalid_1), 32'h0);
    chk("mid_vvalid", 32'(v_valid_1), 32'h0);
    chk("mid_vdata", v_data_1, 32'h0);
    v_re_0 = 1'b0;
    port(1, 15'h0020, 32'h0, 4'h0, 1'b0, 1'b1);
    rst_n = 1'b1;
    #1 chk("post_ready", 32'(a_ready_0), 32'h1);
    cyc();
    idle(0); idle(1);
    chk("post_rvalid", 32'(a_rvalid_1), 32'h1);
    chk("post_data", a_rdata_1, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
